// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter and the caches it serves:
// state encodings, bus size constants and the tie-break helper.
package mem_bus_arbiter_pkg;

  localparam int unsigned ARB_WORD_W = 16;
  localparam int unsigned ARB_LINE_W = 64;
  localparam int unsigned ARB_ADDR_W = 16;

  // Transfer-size encodings carried on the size buses (size in bits)
  localparam int unsigned SIZE_WORD = ARB_WORD_W;
  localparam int unsigned SIZE_LINE = ARB_LINE_W;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN0    = 2'd1,
    ARB_OWN1    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  // Returns 1 when client 1 should be granted; on a tie, client 1 wins unless it owned the port last
  function automatic logic pick_c1(input logic req0, input logic req1, input logic last_c1);
    return req1 & (~req0 | ~last_c1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-client main-memory arbiter for the I-cache (c0) and D-cache (c1).
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to c1.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = ARB_WORD_W,
  parameter int unsigned LINE_W = ARB_LINE_W,
  parameter int unsigned ADDR_W = ARB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_read_m,
  input  logic              c1_read_m,
  input  logic              c0_write_m,
  input  logic              c1_write_m,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [WORD_W-1:0] c0_size,
  input  logic [WORD_W-1:0] c1_size,
  input  logic [LINE_W-1:0] c0_wdata,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic [LINE_W-1:0] c0_rdata,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              c0_ack,
  output logic              c1_ack,
  output logic              c0_granted,
  output logic              c1_granted,
  output logic              m_read_m,
  output logic              m_write_m,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_size,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_ack
);

  arb_state_t        state_q, state_d;
  logic              wr_txn_q, wr_txn_d;
  logic              c0_ack_q, c0_ack_d;
  logic              c1_ack_q, c1_ack_d;
  logic [LINE_W-1:0] c0_rdata_q, c0_rdata_d;
  logic [LINE_W-1:0] c1_rdata_q, c1_rdata_d;

  logic req0;
  logic req1;
  logic last_c1;
  logic grant_c1;

  assign req0     = c0_read_m | c0_write_m;
  assign req1     = c1_read_m | c1_write_m;
  assign grant_c1 = pick_c1(req0, req1, last_c1);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_c1_q, last_c1_d;

  // Remembers which client won the most recent grant; resets to c0
  always_comb begin
    last_c1_d = last_c1_q;
    if ((state_q == ARB_IDLE) && (req0 || req1)) begin
      last_c1_d = grant_c1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_c1_q <= 1'b0;
    end else begin
      last_c1_q <= last_c1_d;
    end
  end

  assign last_c1 = last_c1_q;
`else
  assign last_c1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      wr_txn_q   <= 1'b0;
      c0_ack_q   <= 1'b0;
      c1_ack_q   <= 1'b0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_txn_q   <= wr_txn_d;
      c0_ack_q   <= c0_ack_d;
      c1_ack_q   <= c1_ack_d;
      c0_rdata_q <= c0_rdata_d;
      c1_rdata_q <= c1_rdata_d;
    end
  end

  // Next-state, completion capture and memory-port mux
  always_comb begin
    state_d    = state_q;
    wr_txn_d   = wr_txn_q;
    c0_ack_d   = 1'b0;
    c1_ack_d   = 1'b0;
    c0_rdata_d = c0_rdata_q;
    c1_rdata_d = c1_rdata_q;
    m_read_m   = 1'b0;
    m_write_m  = 1'b0;
    m_addr     = '0;
    m_size     = '0;
    m_wdata    = '0;

    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          if (grant_c1) begin
            state_d  = ARB_OWN1;
            wr_txn_d = c1_write_m;
          end else begin
            state_d  = ARB_OWN0;
            wr_txn_d = c0_write_m;
          end
        end
      end
      ARB_OWN0: begin
        // Write dominates a simultaneous read from the same client
        m_read_m  = c0_read_m & ~c0_write_m;
        m_write_m = c0_write_m;
        m_addr    = c0_addr;
        m_size    = c0_size;
        m_wdata   = c0_wdata;
        if (m_ack) begin
          c0_ack_d = 1'b1;
          if (!wr_txn_q) begin
            c0_rdata_d = m_rdata;
          end
          state_d = ARB_RELEASE;
        end
      end
      ARB_OWN1: begin
        m_read_m  = c1_read_m & ~c1_write_m;
        m_write_m = c1_write_m;
        m_addr    = c1_addr;
        m_size    = c1_size;
        m_wdata   = c1_wdata;
        if (m_ack) begin
          c1_ack_d = 1'b1;
          if (!wr_txn_q) begin
            c1_rdata_d = m_rdata;
          end
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign c0_ack     = c0_ack_q;
  assign c1_ack     = c1_ack_q;
  assign c0_rdata   = c0_rdata_q;
  assign c1_rdata   = c1_rdata_q;
  assign c0_granted = (state_q == ARB_OWN0);
  assign c1_granted = (state_q == ARB_OWN1);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level owner model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 64;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              c0_read_m, c1_read_m, c0_write_m, c1_write_m;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [WORD_W-1:0] c0_size, c1_size;
  logic [LINE_W-1:0] c0_wdata, c1_wdata;
  logic [LINE_W-1:0] c0_rdata, c1_rdata;
  logic              c0_ack, c1_ack, c0_granted, c1_granted;
  logic              m_read_m, m_write_m;
  logic [ADDR_W-1:0] m_addr;
  logic [WORD_W-1:0] m_size;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WORD_W(WORD_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .c0_read_m(c0_read_m), .c1_read_m(c1_read_m),
    .c0_write_m(c0_write_m), .c1_write_m(c1_write_m),
    .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_size(c0_size), .c1_size(c1_size),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .c0_ack(c0_ack), .c1_ack(c1_ack),
    .c0_granted(c0_granted), .c1_granted(c1_granted),
    .m_read_m(m_read_m), .m_write_m(m_write_m),
    .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Owner model: who holds the port (-1 none), whether a cool-down cycle is pending,
  // and what each client has been handed back.
  int          own = -1;
  bit          cool = 1'b0;
  bit          txn_write = 1'b0;
  int          last_winner = 0;
  bit          e_ack0 = 1'b0, e_ack1 = 1'b0;
  logic [63:0] e_rd0 = '0, e_rd1 = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      own <= -1; cool <= 1'b0; txn_write <= 1'b0; last_winner <= 0;
      e_ack0 <= 1'b0; e_ack1 <= 1'b0; e_rd0 <= '0; e_rd1 <= '0;
    end else begin
      e_ack0 <= 1'b0;
      e_ack1 <= 1'b0;
      if (cool) begin
        cool <= 1'b0;
      end else if (own < 0) begin
        bit q0, q1;
        int w;
        q0 = c0_read_m | c0_write_m;
        q1 = c1_read_m | c1_write_m;
        if (q0 && q1) begin
`ifdef ARB_ROUND_ROBIN_EN
          w = (last_winner == 1) ? 0 : 1;
`else
          w = 1;
`endif
        end else if (q1) w = 1;
        else if (q0) w = 0;
        else w = -1;
        own <= w;
        if (w == 0) txn_write <= c0_write_m;
        if (w == 1) txn_write <= c1_write_m;
        if (w >= 0) last_winner <= w;
      end else if (m_ack) begin
        if (own == 0) begin
          e_ack0 <= 1'b1;
          if (!txn_write) e_rd0 <= m_rdata;
        end else begin
          e_ack1 <= 1'b1;
          if (!txn_write) e_rd1 <= m_rdata;
        end
        own  <= -1;
        cool <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [63:0] er, ew, ea, es, ed;
    er = '0; ew = '0; ea = '0; es = '0; ed = '0;
    if (own == 0) begin
      er = 64'(c0_read_m & ~c0_write_m); ew = 64'(c0_write_m);
      ea = 64'(c0_addr); es = 64'(c0_size); ed = 64'(c0_wdata);
    end else if (own == 1) begin
      er = 64'(c1_read_m & ~c1_write_m); ew = 64'(c1_write_m);
      ea = 64'(c1_addr); es = 64'(c1_size); ed = 64'(c1_wdata);
    end
    check("m_read_m", 64'(m_read_m), er);
    check("m_write_m", 64'(m_write_m), ew);
    check("m_addr", 64'(m_addr), ea);
    check("m_size", 64'(m_size), es);
    check("m_wdata", 64'(m_wdata), ed);
    check("c0_granted", 64'(c0_granted), 64'(own == 0));
    check("c1_granted", 64'(c1_granted), 64'(own == 1));
    check("c0_ack", 64'(c0_ack), 64'(e_ack0));
    check("c1_ack", 64'(c1_ack), 64'(e_ack1));
    check("c0_rdata", 64'(c0_rdata), e_rd0);
    check("c1_rdata", 64'(c1_rdata), e_rd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w[4];
    int got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = '{1, 0, 1, 0};
`else
    exp_w = '{1, 1, 1, 1};
`endif
    reset = 1'b0;
    c0_read_m = 0; c1_read_m = 0; c0_write_m = 0; c1_write_m = 0;
    c0_addr = '0; c1_addr = '0; c0_size = '0; c1_size = '0;
    c0_wdata = '0; c1_wdata = '0; m_rdata = '0; m_ack = 0;
    #1 reset = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_c0_rdata", 64'(c0_rdata), 64'h0);
    check("rst_granted", 64'({c0_granted, c1_granted}), 64'h0);

    // c0 line read alone, memory acks in the 4th owned cycle
    step();
    c0_read_m = 1; c0_addr = 16'h0040; c0_size = 16'd64;
    step();
    @(negedge clk);
    check("t1_c0_granted", 64'(c0_granted), 64'h1);
    check("t1_m_read_m", 64'(m_read_m), 64'h1);
    check("t1_m_addr", 64'(m_addr), 64'h0040);
    step(); step(); step();
    m_ack = 1; m_rdata = 64'h1111_2222_3333_4444;
    step();
    m_ack = 0; c0_read_m = 0;
    @(negedge clk);
    check("t1_c0_ack", 64'(c0_ack), 64'h1);
    check("t1_c1_ack", 64'(c1_ack), 64'h0);
    check("t1_c0_rdata", 64'(c0_rdata), 64'h1111_2222_3333_4444);
    step();
    @(negedge clk);
    check("t1_ack_pulse", 64'(c0_ack), 64'h0);

    // c0 read and c1 write together: c1 first, c0 two cycles after c1_ack
    step();
    c0_read_m = 1; c0_addr = 16'h0200; c0_size = 16'd64;
    c1_write_m = 1; c1_addr = 16'h0100; c1_size = 16'd64; c1_wdata = 64'hAAAA;
    step();
    @(negedge clk);
    check("t2_c1_granted", 64'(c1_granted), 64'h1);
    check("t2_c0_granted", 64'(c0_granted), 64'h0);
    check("t2_m_write_m", 64'(m_write_m), 64'h1);
    check("t2_m_wdata", 64'(m_wdata), 64'hAAAA);
    check("t2_m_addr", 64'(m_addr), 64'h0100);
    step();
    m_ack = 1; m_rdata = 64'h9999;
    step();
    m_ack = 0; c1_write_m = 0;
    @(negedge clk);
    check("t2_c1_ack", 64'(c1_ack), 64'h1);
    check("t2_c1_rdata_kept", 64'(c1_rdata), 64'h0);
    step();
    @(negedge clk);
    check("t2_idle_gap", 64'(c0_granted), 64'h0);
    step();
    @(negedge clk);
    check("t2_c0_granted", 64'(c0_granted), 64'h1);
    check("t2_c0_addr", 64'(m_addr), 64'h0200);
    step();
    m_ack = 1; m_rdata = 64'h5555;
    step();
    m_ack = 0; c0_read_m = 0;
    @(negedge clk);
    check("t2_c0_rdata", 64'(c0_rdata), 64'h5555);
    step();

    // Four rounds of simultaneous reads
    for (int r = 0; r < 4; r++) begin
      c0_read_m = 1; c1_read_m = 1;
      c0_addr = 16'(16'h1000 + r); c1_addr = 16'(16'h2000 + r);
      step();
      @(negedge clk);
      got = c1_granted ? 1 : (c0_granted ? 0 : -1);
      check($sformatf("t3_round%0d_winner", r), 64'(got), 64'(exp_w[r]));
      step();
      m_ack = 1; m_rdata = 64'(64'hC0DE_0000 + r);
      step();
      m_ack = 0; c0_read_m = 0; c1_read_m = 0;
      step();
    end

    // Spurious m_ack in IDLE
    m_ack = 1; m_rdata = 64'hBAD;
    step();
    m_ack = 0;
    @(negedge clk);
    check("t4_no_ack", 64'({c0_ack, c1_ack}), 64'h0);
    check("t4_idle", 64'({c0_granted, c1_granted}), 64'h0);

    // Reset in OWN1 mid-access, then a late m_ack
    step();
    c1_write_m = 1; c1_addr = 16'h0500; c1_size = 16'd64; c1_wdata = 64'h1234;
    step();
    @(negedge clk);
    check("t5_c1_granted", 64'(c1_granted), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("t5_async_granted", 64'(c1_granted), 64'h0);
    check("t5_async_m_write", 64'(m_write_m), 64'h0);
    check("t5_async_m_addr", 64'(m_addr), 64'h0);
    check("t5_async_c1_rdata", 64'(c1_rdata), 64'h0);
    step();
    c1_write_m = 0; reset = 1'b0;
    m_ack = 1; m_rdata = 64'hFEED;
    step();
    m_ack = 0;
    @(negedge clk);
    check("t5_late_ack", 64'({c0_ack, c1_ack}), 64'h0);

    // c1 drops its read before m_ack
    step();
    c1_read_m = 1; c1_addr = 16'h0300; c1_size = 16'd16;
    step();
    @(negedge clk);
    check("t6_m_read_m", 64'(m_read_m), 64'h1);
    check("t6_m_size", 64'(m_size), 64'd16);
    step();
    c1_read_m = 0;
    @(negedge clk);
    check("t6_strobe_drop", 64'(m_read_m), 64'h0);
    check("t6_still_owned", 64'(c1_granted), 64'h1);
    step();
    m_ack = 1; m_rdata = 64'hDEAD_BEEF_0123_4567;
    step();
    m_ack = 0;
    @(negedge clk);
    check("t6_c1_ack", 64'(c1_ack), 64'h1);
    check("t6_c1_rdata", 64'(c1_rdata), 64'hDEAD_BEEF_0123_4567);

    // Read and write together from c0 is a write
    step();
    c0_read_m = 1; c0_write_m = 1; c0_addr = 16'h0700; c0_wdata = 64'h77;
    step();
    @(negedge clk);
    check("t7_m_read_m", 64'(m_read_m), 64'h0);
    check("t7_m_write_m", 64'(m_write_m), 64'h1);
    step();
    m_ack = 1; m_rdata = 64'hFFFF;
    step();
    m_ack = 0; c0_read_m = 0; c0_write_m = 0;
    @(negedge clk);
    check("t7_c0_ack", 64'(c0_ack), 64'h1);
    check("t7_c0_rdata_kept", 64'(c0_rdata), 64'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
